// File: rtl/max_index_selector_pkg.sv
// Shared types and constants for the classifier argmax pipeline.
package max_index_selector_pkg;

  localparam int unsigned DATA_W     = 26;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned N_IN       = 10;
  localparam int unsigned MAXSEL_LAT = 4;

  // Candidate score tagged with the class number it came from.
  typedef struct packed {
    logic signed [DATA_W-1:0] val;
    logic [IDX_W-1:0]         idx;
  } cand_t;

  // True when x should replace y: strictly larger score, or equal score with a lower index.
  function automatic logic cand_beats(input cand_t x, input cand_t y);
    logic signed [DATA_W-1:0] xv;
    logic signed [DATA_W-1:0] yv;
    xv = x.val;
    yv = y.val;
    return (xv > yv) || ((xv == yv) && (x.idx < y.idx));
  endfunction

endpackage

// File: rtl/max_index_selector_max2_cell.sv
// Combinational two-way compare; the winner keeps its original index.
module max2_cell
  import max_index_selector_pkg::*;
(
  input  cand_t a,
  input  cand_t b,
  output cand_t win_c
);

  // Pick the larger signed score, lower index on ties.
  always_comb begin
    win_c = a;
    if (cand_beats(b, a)) begin
      win_c = b;
    end
  end

endmodule

// File: rtl/max_index_selector.sv
// Four-stage pipelined argmax over ten signed class scores; one vector per clock.
module max_index_selector
  import max_index_selector_pkg::*;
(
  input  logic                     clk,
  input  logic                     GlobalReset,
  input  logic signed [DATA_W-1:0] Out_0,
  input  logic signed [DATA_W-1:0] Out_1,
  input  logic signed [DATA_W-1:0] Out_2,
  input  logic signed [DATA_W-1:0] Out_3,
  input  logic signed [DATA_W-1:0] Out_4,
  input  logic signed [DATA_W-1:0] Out_5,
  input  logic signed [DATA_W-1:0] Out_6,
  input  logic signed [DATA_W-1:0] Out_7,
  input  logic signed [DATA_W-1:0] Out_8,
  input  logic signed [DATA_W-1:0] Out_9,
  output logic [IDX_W-1:0]         Out
);

  localparam int unsigned N_S1 = 5;
  localparam int unsigned N_S2 = 3;
  localparam int unsigned N_S3 = 2;

  cand_t in_c [N_IN];
  cand_t s1_c [N_S1];
  cand_t s1_q [N_S1];
  cand_t s2_c [N_S2];
  cand_t s2_q [N_S2];
  cand_t s3_c [N_S3];
  cand_t s3_q [N_S3];
  cand_t fin_c;

  // The final winning score is not needed downstream; only its index leaves the block.
  logic [DATA_W-1:0] fin_val_unused;
  assign fin_val_unused = fin_c.val;

  // Tag each raw score with its class number.
  always_comb begin
    in_c[0] = '{val: Out_0, idx: IDX_W'(0)};
    in_c[1] = '{val: Out_1, idx: IDX_W'(1)};
    in_c[2] = '{val: Out_2, idx: IDX_W'(2)};
    in_c[3] = '{val: Out_3, idx: IDX_W'(3)};
    in_c[4] = '{val: Out_4, idx: IDX_W'(4)};
    in_c[5] = '{val: Out_5, idx: IDX_W'(5)};
    in_c[6] = '{val: Out_6, idx: IDX_W'(6)};
    in_c[7] = '{val: Out_7, idx: IDX_W'(7)};
    in_c[8] = '{val: Out_8, idx: IDX_W'(8)};
    in_c[9] = '{val: Out_9, idx: IDX_W'(9)};
  end

  // Stage 1: five adjacent pairs.
  for (genvar g = 0; g < N_S1; g++) begin : g_s1
    max2_cell u_cell (
      .a     (in_c[2*g]),
      .b     (in_c[2*g+1]),
      .win_c (s1_c[g])
    );
  end

  // Stage 2: two compares, fifth winner passes through.
  for (genvar g = 0; g < 2; g++) begin : g_s2
    max2_cell u_cell (
      .a     (s1_q[2*g]),
      .b     (s1_q[2*g+1]),
      .win_c (s2_c[g])
    );
  end
  assign s2_c[2] = s1_q[4];

  // Stage 3: one compare, pass-through candidate carried along.
  max2_cell u_s3 (
    .a     (s2_q[0]),
    .b     (s2_q[1]),
    .win_c (s3_c[0])
  );
  assign s3_c[1] = s2_q[2];

  // Stage 4: final compare.
  max2_cell u_s4 (
    .a     (s3_q[0]),
    .b     (s3_q[1]),
    .win_c (fin_c)
  );

  // Stage 1 registers.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int i = 0; i < N_S1; i++) s1_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_S1; i++) s1_q[i] <= s1_c[i];
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int i = 0; i < N_S2; i++) s2_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_S2; i++) s2_q[i] <= s2_c[i];
    end
  end

  // Stage 3 registers.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int i = 0; i < N_S3; i++) s3_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_S3; i++) s3_q[i] <= s3_c[i];
    end
  end

  // Stage 4: registered winning index.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      Out <= '0;
    end else begin
      Out <= fin_c.idx;
    end
  end

endmodule

// File: tb/tb_max_index_selector.sv
// Directed bench for max_index_selector with a cycle-by-cycle argmax model.
module tb_max_index_selector;
  import max_index_selector_pkg::*;

  logic                     clk;
  logic                     GlobalReset;
  logic signed [DATA_W-1:0] vec [N_IN];
  logic [IDX_W-1:0]         out_w;

  int tests;
  int errors;

  logic [IDX_W-1:0] hist [$];

  max_index_selector dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .Out_0       (vec[0]),
    .Out_1       (vec[1]),
    .Out_2       (vec[2]),
    .Out_3       (vec[3]),
    .Out_4       (vec[4]),
    .Out_5       (vec[5]),
    .Out_6       (vec[6]),
    .Out_7       (vec[7]),
    .Out_8       (vec[8]),
    .Out_9       (vec[9]),
    .Out         (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [IDX_W-1:0] got, input logic [IDX_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference argmax straight from the rules: first index holding the largest signed value.
  function automatic logic [IDX_W-1:0] model_argmax();
    int best;
    best = 0;
    for (int i = 1; i < N_IN; i++) begin
      if (vec[i] > vec[best]) best = i;
    end
    return IDX_W'(best);
  endfunction

  // History of results for vectors captured since the last reset.
  always @(posedge clk) begin
    if (!GlobalReset) begin
      hist.delete();
    end else begin
      hist.push_back(model_argmax());
      if (hist.size() > MAXSEL_LAT) void'(hist.pop_front());
    end
  end

  always @(negedge GlobalReset) hist.delete();

  // Every cycle: Out must equal the argmax of the vector captured MAXSEL_LAT edges ago, else 0.
  always @(negedge clk) begin
    logic [IDX_W-1:0] exp;
    exp = (hist.size() == MAXSEL_LAT) ? hist[0] : '0;
    check("model", out_w, exp);
  end

  task automatic set_all(input logic signed [DATA_W-1:0] v);
    for (int i = 0; i < N_IN; i++) vec[i] = v;
  endtask

  task automatic set_peak(input int idx);
    set_all(DATA_W'(5));
    vec[idx] = DATA_W'(1000);
  endtask

  // Vector already applied at edge+2; hold it for one edge, swap in a decoy, check at the 4th edge.
  task automatic run_lit(input string name, input logic [IDX_W-1:0] exp);
    @(posedge clk);
    #2;
    set_peak(5);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    check(name, out_w, exp);
    #1;
  endtask

  initial begin
    tests = 0;
    errors = 0;
    GlobalReset = 1'b0;
    for (int i = 0; i < N_IN; i++) vec[i] = DATA_W'($urandom);

    // Reset held with random inputs.
    repeat (4) @(posedge clk);
    #1;
    check("reset_hold", out_w, 4'd0);
    #1;
    GlobalReset = 1'b1;

    set_peak(7);
    run_lit("peak7", 4'd7);
    set_peak(0);
    run_lit("peak0", 4'd0);
    set_peak(9);
    run_lit("peak9", 4'd9);

    set_all(26'sh2000000);
    vec[3] = -26'sd1;
    vec[5] = -26'sd2;
    run_lit("signed_neg", 4'd3);

    set_all(26'sd0);
    vec[2] = 26'sh1FFFFFF;
    vec[8] = 26'sh2000000;
    run_lit("signed_extremes", 4'd2);

    set_all(26'sd100);
    vec[4] = 26'sd500;
    vec[6] = 26'sd500;
    run_lit("tie_4_6", 4'd4);

    set_all(26'sd42);
    run_lit("all_equal", 4'd0);

    set_all(-26'sd7);
    vec[8] = -26'sd3;
    vec[9] = -26'sd3;
    run_lit("tie_8_9", 4'd8);

    set_all(26'sd0);
    vec[1] = 26'sd77;
    vec[8] = 26'sd77;
    run_lit("tie_1_8", 4'd1);

    // Back-to-back stream of peaks 1..9,0.
    for (int i = 0; i < 13; i++) begin
      if (i < 10) set_peak((i + 1) % 10);
      else set_all(26'sd0);
      @(posedge clk);
      #1;
      if (i >= 3) check("stream", out_w, IDX_W'((i - 3 + 1) % 10));
      #1;
    end

    // Stream again, then a one-cycle reset in the middle.
    for (int i = 0; i < 6; i++) begin
      set_peak((i + 1) % 10);
      @(posedge clk);
      #1;
      if (i >= 3) check("stream2", out_w, IDX_W'((i - 3 + 1) % 10));
      #1;
    end
    #1;
    GlobalReset = 1'b0;
    #1;
    check("async_reset", out_w, 4'd0);
    @(posedge clk);
    #1;
    check("reset_edge", out_w, 4'd0);
    #1;
    GlobalReset = 1'b1;
    set_peak(8);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      check("post_reset", out_w, (j == 3) ? 4'd8 : 4'd0);
      #1;
      if (j == 0) set_peak(2);
    end

    repeat (6) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
